// File: rtl/reset_sequencer_if.sv
// Request/status bundle between a reset requester and the reset_sequencer.
// The requester drives req/hold/stagger; the sequencer returns the per-channel reset state.
interface reset_sequencer_if #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned HOLD_W    = 32,
    parameter int unsigned STAGGER_W = 16
);
    logic [CHANNELS-1:0]  req;
    logic [HOLD_W-1:0]    hold_cycles;
    logic [STAGGER_W-1:0] stagger_cycles;
    logic [CHANNELS-1:0]  rst_n_out;
    logic [CHANNELS-1:0]  active_mask;
    logic                 busy;
    logic                 done;

    modport master (
        output req,
        output hold_cycles,
        output stagger_cycles,
        input  rst_n_out,
        input  active_mask,
        input  busy,
        input  done
    );

    modport slave (
        input  req,
        input  hold_cycles,
        input  stagger_cycles,
        output rst_n_out,
        output active_mask,
        output busy,
        output done
    );
endinterface

// File: rtl/reset_sequencer.sv
// N-channel active-low reset pulse generator: hold all requested channels, then release them in index order.
// Optional feature macro: RESET_SEQ_STATUS_LED_EN adds status_led_o driven by a free-running blink counter.
module reset_sequencer #(
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned HOLD_W        = 32,
    parameter int unsigned STAGGER_W     = 16,
    parameter int unsigned LED_BLINK_BIT = 22
) (
    input  logic             clock_i,
    input  logic             nreset_i,
    reset_sequencer_if.slave bus
`ifdef RESET_SEQ_STATUS_LED_EN
    ,
    output logic             status_led_o
`endif
);

    localparam int unsigned CNT_W = (HOLD_W > STAGGER_W) ? HOLD_W : STAGGER_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STAGGER = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CHANNELS-1:0] mask_q;
    logic [CHANNELS-1:0] rst_n_q;
    logic                busy_q;
    logic                done_q;

    logic [CHANNELS-1:0] lower_set;
    logic [CHANNELS-1:0] first_bit;
    logic [CHANNELS-1:0] mask_after;
    logic [CHANNELS-1:0] mask_req;
    logic [CNT_W-1:0]    hold_load;
    logic [CNT_W-1:0]    stagger_load;
    logic                any_req;

    genvar gi;

    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("reset_sequencer: CHANNELS must be 1..8");
    end
    if (LED_BLINK_BIT > 63) begin : g_bad_blink
        $error("reset_sequencer: LED_BLINK_BIT must be below 64");
    end

    // Lowest-index pending channel: a bit is first when no lower bit is still pending.
    for (gi = 0; gi < CHANNELS; gi++) begin : g_prio
        if (gi == 0) begin : g_lsb
            assign lower_set[gi] = 1'b0;
        end else begin : g_upper
            assign lower_set[gi] = |mask_q[gi-1:0];
        end
        assign first_bit[gi] = mask_q[gi] & ~lower_set[gi];
    end

    assign any_req      = |bus.req;
    assign mask_req     = mask_q | bus.req;
    assign mask_after   = (bus.stagger_cycles == '0) ? '0 : (mask_q & ~first_bit);
    assign hold_load    = (bus.hold_cycles == '0) ? '0
                        : (CNT_W'(bus.hold_cycles) - CNT_W'(1));
    assign stagger_load = CNT_W'(bus.stagger_cycles) - CNT_W'(1);

    // The release step is taken on the edge that ends a HOLD/STAGGER count, so a channel
    // rises exactly hold (or stagger) cycles after its count was loaded.
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            rst_n_q <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (any_req) begin
                // New or repeated request always wins over a pending release.
                state_q <= ST_HOLD;
                cnt_q   <= hold_load;
                mask_q  <= mask_req;
                rst_n_q <= ~mask_req;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                    ST_HOLD, ST_STAGGER: begin
                        if (cnt_q == '0) begin
                            mask_q  <= mask_after;
                            rst_n_q <= ~mask_after;
                            if (mask_after == '0) begin
                                state_q <= ST_IDLE;
                                cnt_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_STAGGER;
                                cnt_q   <= stagger_load;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        mask_q  <= '0;
                        rst_n_q <= '1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rst_n_out   = rst_n_q;
    assign bus.active_mask = mask_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

`ifdef RESET_SEQ_STATUS_LED_EN
    localparam int unsigned BLINK_W = LED_BLINK_BIT + 1;

    logic [BLINK_W-1:0] blink_q;
    logic               led_q;

    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            blink_q <= '0;
            led_q   <= 1'b0;
        end else begin
            blink_q <= blink_q + BLINK_W'(1);
            led_q   <= busy_q & blink_q[LED_BLINK_BIT];
        end
    end

    assign status_led_o = led_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scoreboard bench for reset_sequencer: stimulus queues per-cycle expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    reset_sequencer_if #(.CHANNELS(2), .HOLD_W(32), .STAGGER_W(16)) bus ();

`ifdef RESET_SEQ_STATUS_LED_EN
    logic status_led;
`endif

    reset_sequencer #(
        .CHANNELS(2), .HOLD_W(32), .STAGGER_W(16), .LED_BLINK_BIT(22)
    ) dut (
        .clock_i (clk),
        .nreset_i(nreset),
        .bus     (bus)
`ifdef RESET_SEQ_STATUS_LED_EN
        ,
        .status_led_o(status_led)
`endif
    );

    typedef struct {
        int         cyc;
        logic [1:0] rst;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   base  = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue expected outputs for cycles base+lo .. base+hi.
    function automatic void expect_span(input string name, input int lo, input int hi,
                                        input logic [1:0] rst, input logic busy, input logic done);
        for (int c = lo; c <= hi; c++) begin
            exp_t e;
            e.cyc  = base + c;
            e.rst  = rst;
            e.busy = busy;
            e.done = done;
            e.name = $sformatf("%s@%0d", name, c);
            exp_q.push_back(e);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT against the scoreboard on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                tests++;
                if (e.cyc < cyc) begin
                    fails++;
                    $display("FAIL %s: expectation for cycle %0d missed, now cycle %0d", e.name, e.cyc, cyc);
                end else if (bus.rst_n_out !== e.rst || bus.active_mask !== ~e.rst ||
                             bus.busy !== e.busy || bus.done !== e.done) begin
                    fails++;
                    $display("FAIL %s: got rst_n_out=%b active_mask=%b busy=%b done=%b, expected rst_n_out=%b active_mask=%b busy=%b done=%b",
                             e.name, bus.rst_n_out, bus.active_mask, bus.busy, bus.done,
                             e.rst, ~e.rst, e.busy, e.done);
                end
`ifdef RESET_SEQ_STATUS_LED_EN
                tests++;
                if (status_led !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_led: got status_led=%b, expected 0", e.name, status_led);
                end
`endif
            end
        end
    end

    initial begin
        bus.req            = '0;
        bus.hold_cycles    = '0;
        bus.stagger_cycles = '0;
        nreset             = 1'b0;

        // Reset values held for 10 cycles.
        step(1);
        base = cyc;
        expect_span("reset", 0, 9, 2'b11, 1'b0, 1'b0);
        step(10);
        nreset = 1'b1;
        $display("[TB] reset: outputs checked for 10 cycles with nreset low");
        step(3);

        // hold=4 stagger=2, both channels.
        base = cyc;
        bus.hold_cycles = 4; bus.stagger_cycles = 2; bus.req = 2'b11;
        expect_span("basic", 0, 0, 2'b11, 1'b0, 1'b0);
        expect_span("basic", 1, 4, 2'b00, 1'b1, 1'b0);
        expect_span("basic", 5, 6, 2'b01, 1'b1, 1'b0);
        expect_span("basic", 7, 7, 2'b11, 1'b0, 1'b1);
        expect_span("basic", 8, 9, 2'b11, 1'b0, 1'b0);
        step(1); bus.req = '0;
        step(10);
        $display("[TB] basic: hold=4 stagger=2 req=11 issued at cycle %0d", base);

        // hold=0 stagger=0 behaves as a one-cycle pulse.
        base = cyc;
        bus.hold_cycles = 0; bus.stagger_cycles = 0; bus.req = 2'b01;
        expect_span("zero", 0, 0, 2'b11, 1'b0, 1'b0);
        expect_span("zero", 1, 1, 2'b10, 1'b1, 1'b0);
        expect_span("zero", 2, 2, 2'b11, 1'b0, 1'b1);
        expect_span("zero", 3, 3, 2'b11, 1'b0, 1'b0);
        step(1); bus.req = '0;
        step(4);
        $display("[TB] zero: hold=0 stagger=0 req=01 issued at cycle %0d", base);

        // Retrigger of ch0 while ch1 is still pending.
        base = cyc;
        bus.hold_cycles = 4; bus.stagger_cycles = 3; bus.req = 2'b11;
        expect_span("retrig", 1, 4, 2'b00, 1'b1, 1'b0);
        expect_span("retrig", 5, 6, 2'b01, 1'b1, 1'b0);
        expect_span("retrig", 7, 10, 2'b00, 1'b1, 1'b0);
        expect_span("retrig", 11, 13, 2'b01, 1'b1, 1'b0);
        expect_span("retrig", 14, 14, 2'b11, 1'b0, 1'b1);
        expect_span("retrig", 15, 15, 2'b11, 1'b0, 1'b0);
        step(1); bus.req = '0;
        step(5); bus.req = 2'b01;
        step(1); bus.req = '0;
        step(10);
        $display("[TB] retrig: req=11 then req=01 at +6, issued at cycle %0d", base);

        // Level request held for 20 cycles.
        base = cyc;
        bus.hold_cycles = 5; bus.stagger_cycles = 2; bus.req = 2'b10;
        expect_span("level", 1, 24, 2'b01, 1'b1, 1'b0);
        expect_span("level", 25, 25, 2'b11, 1'b0, 1'b1);
        expect_span("level", 26, 26, 2'b11, 1'b0, 1'b0);
        step(20); bus.req = '0;
        step(8);
        $display("[TB] level: req=10 held 20 cycles hold=5, issued at cycle %0d", base);

        // Request coincides with the final release: retrigger wins, no done.
        base = cyc;
        bus.hold_cycles = 2; bus.stagger_cycles = 0; bus.req = 2'b01;
        expect_span("collide", 1, 2, 2'b10, 1'b1, 1'b0);
        expect_span("collide", 3, 4, 2'b00, 1'b1, 1'b0);
        expect_span("collide", 5, 5, 2'b11, 1'b0, 1'b1);
        expect_span("collide", 6, 6, 2'b11, 1'b0, 1'b0);
        step(1); bus.req = '0;
        step(1); bus.req = 2'b10;
        step(1); bus.req = '0;
        step(6);
        $display("[TB] collide: req=10 on final-release cycle, issued at cycle %0d", base);

        // hold_cycles change after load has no effect on the running count.
        base = cyc;
        bus.hold_cycles = 3; bus.stagger_cycles = 5; bus.req = 2'b01;
        expect_span("sample", 1, 3, 2'b10, 1'b1, 1'b0);
        expect_span("sample", 4, 4, 2'b11, 1'b0, 1'b1);
        expect_span("sample", 5, 5, 2'b11, 1'b0, 1'b0);
        step(1); bus.req = '0; bus.hold_cycles = 10; bus.stagger_cycles = 7;
        step(6);
        $display("[TB] sample: hold 3 changed to 10 mid-count, issued at cycle %0d", base);

        // Minimum nonzero hold and stagger.
        base = cyc;
        bus.hold_cycles = 1; bus.stagger_cycles = 1; bus.req = 2'b11;
        expect_span("min", 1, 1, 2'b00, 1'b1, 1'b0);
        expect_span("min", 2, 2, 2'b01, 1'b1, 1'b0);
        expect_span("min", 3, 3, 2'b11, 1'b0, 1'b1);
        expect_span("min", 4, 4, 2'b11, 1'b0, 1'b0);
        step(1); bus.req = '0;
        step(5);
        $display("[TB] min: hold=1 stagger=1 req=11 issued at cycle %0d", base);

        // Asynchronous block reset in the middle of a sequence.
        base = cyc;
        bus.hold_cycles = 4; bus.stagger_cycles = 2; bus.req = 2'b11;
        expect_span("midrst", 1, 2, 2'b00, 1'b1, 1'b0);
        expect_span("midrst", 3, 9, 2'b11, 1'b0, 1'b0);
        step(1); bus.req = '0;
        step(2);
        #2 nreset = 1'b0;
        step(2);
        nreset = 1'b1;
        step(6);
        $display("[TB] midrst: nreset low at +3 of hold=4 sequence, issued at cycle %0d", base);

        step(2);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d unchecked expectations, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
